// File: rtl/cm0ik_misc_delay_line.sv
// cm0ik_misc_delay_line
// Run-time selectable multi-channel delay line (0..DEPTH enabled fclk ticks)
// with shift-enable stall, synchronous flush, settled flag and per-channel
// rising-edge pulse on the delayed output.
module cm0ik_misc_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DLY_W = 5
) (
  input  logic             fclk,
  input  logic             hresetn,
  input  logic             en,
  input  logic             flush,
  input  logic [DLY_W-1:0] dly,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic             valid,
  output logic [WIDTH-1:0] rise
);

  localparam logic [DLY_W-1:0] DEPTH_C = DLY_W'(DEPTH);

  logic [WIDTH-1:0] d [DEPTH];
  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] eff;
  logic [WIDTH-1:0] o_q;

  // Clamp the requested delay to the number of physical stages
  always_comb begin
    eff = (dly > DEPTH_C) ? DEPTH_C : dly;
  end

  // Shift register: flush clears, en advances, otherwise hold
  always_ff @(posedge fclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int unsigned k = 0; k < DEPTH; k++) d[k] <= '0;
    end else if (flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) d[k] <= '0;
    end else if (en) begin
      d[0] <= i;
      for (int unsigned k = 1; k < DEPTH; k++) d[k] <= d[k-1];
    end
  end

  // Settle counter: number of valid samples held, saturating at DEPTH
  always_ff @(posedge fclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (en && (cnt < DEPTH_C)) begin
      cnt <= cnt + DLY_W'(1);
    end
  end

  // Output tap select; eff=0 bypasses the pipeline combinationally
  always_comb begin
    o = i;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (eff == DLY_W'(k + 1)) o = d[k];
    end
  end

  // Settled once at least eff samples have been shifted in
  always_comb begin
    valid = (cnt >= eff);
  end

  // Previous-cycle copy of o, loaded every edge regardless of en/flush
  always_ff @(posedge fclk or negedge hresetn) begin
    if (!hresetn) begin
      o_q <= '0;
    end else begin
      o_q <= o;
    end
  end

  // Per-channel 0->1 detector on the delayed output
  always_comb begin
    rise = o & ~o_q;
  end

endmodule

// File: tb/tb_cm0ik_misc_delay_line.sv
// tb_cm0ik_misc_delay_line
// Directed scenarios drive one cycle at a time and queue the expected
// outputs for that cycle; a monitor pops and compares on the falling edge.
module tb_cm0ik_misc_delay_line;

  logic       fclk = 1'b0;
  logic       hresetn;
  logic       en;
  logic       flush;
  logic [4:0] dly;
  logic [3:0] i;
  logic [3:0] o;
  logic       valid;
  logic [3:0] rise;

  typedef struct {
    logic [3:0] o;
    logic       valid;
    logic [3:0] rise;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  cm0ik_misc_delay_line #(
    .WIDTH(4),
    .DEPTH(16),
    .DLY_W(5)
  ) dut (
    .fclk   (fclk),
    .hresetn(hresetn),
    .en     (en),
    .flush  (flush),
    .dly    (dly),
    .i      (i),
    .o      (o),
    .valid  (valid),
    .rise   (rise)
  );

  always #5 fclk = ~fclk;

  task automatic push(input logic [3:0] eo, input logic ev, input logic [3:0] er,
                      input string nm);
    exp_t e;
    e.o = eo; e.valid = ev; e.rise = er; e.name = nm;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, queue that cycle's expected outputs, advance
  task automatic step(input logic e, input logic f, input logic [4:0] dv,
                      input logic [3:0] iv, input logic [3:0] eo, input logic ev,
                      input logic [3:0] er, input string nm);
    en = e; flush = f; dly = dv; i = iv;
    push(eo, ev, er, nm);
    @(posedge fclk); #1;
  endtask

  // Hold reset for one edge, checking outputs while reset is asserted
  task automatic do_reset(input logic [4:0] dv, input logic [3:0] iv,
                          input logic [3:0] eo, input logic ev, input logic [3:0] er,
                          input string nm);
    hresetn = 1'b0; en = 1'b1; flush = 1'b0; dly = dv; i = iv;
    push(eo, ev, er, nm);
    @(posedge fclk); #1;
    hresetn = 1'b1;
  endtask

  task automatic check4(input string nm, input string f, input logic [3:0] act,
                        input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%h expected=%h", nm, f, act, exp);
    end
  endtask

  // Monitor: compare the queued expectation against the live outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge fclk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check4(e.name, "o", o, e.o);
        check4(e.name, "valid", {3'b000, valid}, {3'b000, e.valid});
        check4(e.name, "rise", rise, e.rise);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] s6_in  [6];
    logic [3:0] s6_o   [6];
    logic [3:0] s6_r   [6];
    s6_in = '{4'h5, 4'hA, 4'hF, 4'h5, 4'hA, 4'h0};
    s6_o  = '{4'h0, 4'h0, 4'h0, 4'h5, 4'hA, 4'hF};
    s6_r  = '{4'h0, 4'h0, 4'h0, 4'h5, 4'hA, 4'h5};

    hresetn = 1'b0; en = 1'b0; flush = 1'b0; dly = 5'd4; i = 4'h0;
    @(posedge fclk); #1;

    // 1: dly=4, single pulse sampled at edge 11 shows in cycle 14 only
    do_reset(5'd4, 4'h0, 4'h0, 1'b0, 4'h0, "s1_reset");
    for (int k = 0; k < 20; k++)
      step(1'b1, 1'b0, 5'd4, (k == 10) ? 4'h1 : 4'h0,
           (k == 14) ? 4'h1 : 4'h0, (k >= 4), (k == 14) ? 4'h1 : 4'h0,
           $sformatf("s1_c%0d", k));

    // 2: dly=0 bypass; rise follows i during reset, valid always 1
    do_reset(5'd0, 4'h1, 4'h1, 1'b1, 4'h1, "s2_reset");
    step(1'b1, 1'b0, 5'd0, 4'h1, 4'h1, 1'b1, 4'h1, "s2_c0");
    step(1'b0, 1'b0, 5'd0, 4'h0, 4'h0, 1'b1, 4'h0, "s2_c1");
    step(1'b1, 1'b0, 5'd0, 4'h1, 4'h1, 1'b1, 4'h1, "s2_c2");
    step(1'b1, 1'b0, 5'd0, 4'h1, 4'h1, 1'b1, 4'h0, "s2_c3");

    // 3: dly=20 clamps to 16; pulse sampled at edge 1 shows in cycle 16
    do_reset(5'd20, 4'h0, 4'h0, 1'b0, 4'h0, "s3_reset");
    for (int k = 0; k < 40; k++)
      step(1'b1, 1'b0, 5'd20, (k == 0) ? 4'h1 : 4'h0,
           (k == 16) ? 4'h1 : 4'h0, (k >= 16), (k == 16) ? 4'h1 : 4'h0,
           $sformatf("s3_c%0d", k));

    // 4: as 1, but en=0 at edges 12..14 pushes the pulse to cycle 17
    do_reset(5'd4, 4'h0, 4'h0, 1'b0, 4'h0, "s4_reset");
    for (int k = 0; k < 22; k++)
      step(!(k >= 11 && k <= 13), 1'b0, 5'd4, (k == 10) ? 4'h1 : 4'h0,
           (k == 17) ? 4'h1 : 4'h0, (k >= 4), (k == 17) ? 4'h1 : 4'h0,
           $sformatf("s4_c%0d", k));

    // 5: fill with 1s, flush at edge 20 with i=1; that sample is dropped
    do_reset(5'd4, 4'h0, 4'h0, 1'b0, 4'h0, "s5_reset");
    for (int k = 0; k < 28; k++)
      step(1'b1, (k == 19), 5'd4, (k <= 19) ? 4'h1 : 4'h0,
           (k >= 4 && k <= 19) ? 4'h1 : 4'h0,
           (k >= 4 && k <= 19) || (k >= 24),
           (k == 4) ? 4'h1 : 4'h0,
           $sformatf("s5_c%0d", k));

    // 6: 4-bit stream with dly=3, then async reset mid-stream
    do_reset(5'd3, 4'h0, 4'h0, 1'b0, 4'h0, "s6_reset");
    for (int k = 0; k < 6; k++)
      step(1'b1, 1'b0, 5'd3, s6_in[k], s6_o[k], (k >= 3), s6_r[k],
           $sformatf("s6_c%0d", k));
    do_reset(5'd3, 4'h0, 4'h0, 1'b0, 4'h0, "s6_async_reset");
    for (int k = 0; k < 6; k++)
      step(1'b1, 1'b0, 5'd3, (k == 2) ? 4'h3 : 4'h0,
           (k == 5) ? 4'h3 : 4'h0, (k >= 3), (k == 5) ? 4'h3 : 4'h0,
           $sformatf("s6_post_c%0d", k));

    repeat (3) @(negedge fclk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d expected=0 pending", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
